// File: rtl/pipe_ctrl_pkg.sv
// Shared types and default timing constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_MD_WAIT   = 2'd1,
        ST_EXC_DRAIN = 2'd2,
        ST_EXC_REDIR = 2'd3
    } ctrl_state_e;

    localparam int MD_LAT_DEF    = 32;
    localparam int EXC_DRAIN_DEF = 2;
    localparam int CNT_W_DEF     = 6;

endpackage

// File: rtl/hazard_down_counter.sv
// Loadable down-counter shared by the mult/div wait and exception drain phases.
// Load wins over decrement; the counter saturates at zero.
module hazard_down_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Prioritised stall/flush controller for the 5-stage pipeline (zero-latency responses).
// Optional perf counters enabled with HAZ_PERF_EN; otherwise stall_cnt/flush_cnt read zero.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_LAT    = MD_LAT_DEF,
    parameter int EXC_DRAIN = EXC_DRAIN_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lu_hazard,
    input  logic        br_hazard,
    input  logic        skip_flush,
    input  logic        md_start,
    input  logic        exc_req,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        id_ex_bubble,
    output logic        if_flush,
    output logic        ex_flush,
    output logic        pc_sel_exc,
    output logic        md_busy,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    localparam logic [CNT_W-1:0] MD_LOAD  = CNT_W'(MD_LAT - 1);
    localparam logic [CNT_W-1:0] EXC_LOAD = CNT_W'(EXC_DRAIN - 1);

    ctrl_state_e      state_q;
    ctrl_state_e      state_d;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_dec;
    logic             cnt_zero;

    hazard_down_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b0;
        if_flush     = 1'b0;
        ex_flush     = 1'b0;
        pc_sel_exc   = 1'b0;
        md_busy      = 1'b0;
        if (rst_n) begin
            case (state_q)
                ST_RUN, ST_MD_WAIT: begin
                    if (exc_req) begin
                        // Accept cycle still reports the aborted mult/div as busy.
                        ex_flush     = 1'b1;
                        if_flush     = 1'b1;
                        id_ex_bubble = 1'b1;
                        md_busy      = (state_q == ST_MD_WAIT);
                        cnt_load     = 1'b1;
                        cnt_load_val = EXC_LOAD;
                        state_d      = ST_EXC_DRAIN;
                    end else if (state_q == ST_MD_WAIT) begin
                        id_ex_bubble = 1'b1;
                        md_busy      = 1'b1;
                        if (cnt_zero) begin
                            state_d = ST_RUN;
                        end else begin
                            cnt_dec = 1'b1;
                        end
                    end else if (md_start) begin
                        pc_write     = 1'b1;
                        if_id_write  = 1'b1;
                        cnt_load     = 1'b1;
                        cnt_load_val = MD_LOAD;
                        state_d      = ST_MD_WAIT;
                    end else if (lu_hazard || br_hazard) begin
                        // Stalled branch re-presents next cycle, so skip_flush is dropped here.
                        id_ex_bubble = 1'b1;
                    end else begin
                        pc_write    = 1'b1;
                        if_id_write = 1'b1;
                        if_flush    = skip_flush;
                    end
                end
                ST_EXC_DRAIN: begin
                    id_ex_bubble = 1'b1;
                    if (cnt_zero) begin
                        state_d = ST_EXC_REDIR;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                ST_EXC_REDIR: begin
                    pc_write   = 1'b1;
                    pc_sel_exc = 1'b1;
                    if_flush   = 1'b1;
                    state_d    = ST_RUN;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

`ifdef HAZ_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!pc_write) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (if_flush) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomised and directed bench for pipe_hazard_ctrl against a queue-based schedule model.
module tb_pipe_hazard_ctrl;

    localparam int MD_LAT    = 4;
    localparam int EXC_DRAIN = 2;
    localparam int K_MD      = 1;
    localparam int K_DRAIN   = 2;
    localparam int K_REDIR   = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lu_hazard, br_hazard, skip_flush, md_start, exc_req;
    logic        pc_write, if_id_write, id_ex_bubble, if_flush, ex_flush, pc_sel_exc, md_busy;
    logic [31:0] stall_cnt, flush_cnt;

    int errors = 0;
    int checks = 0;

    pipe_hazard_ctrl #(
        .MD_LAT    (MD_LAT),
        .EXC_DRAIN (EXC_DRAIN),
        .CNT_W     (6)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lu_hazard    (lu_hazard),
        .br_hazard    (br_hazard),
        .skip_flush   (skip_flush),
        .md_start     (md_start),
        .exc_req      (exc_req),
        .pc_write     (pc_write),
        .if_id_write  (if_id_write),
        .id_ex_bubble (id_ex_bubble),
        .if_flush     (if_flush),
        .ex_flush     (ex_flush),
        .pc_sel_exc   (pc_sel_exc),
        .md_busy      (md_busy),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pending forced cycles are held in a queue; each entry is one future cycle.
    int          sched[$];
    int unsigned m_stall = 0;
    int unsigned m_flush = 0;
    bit          perf_ok = 1'b0;

    always @(negedge clk) begin
        logic [6:0] e;   // {pcw, ifid, bub, iff, exf, sel, busy}
        int front;
        if (!rst_n) begin
            e = 7'b0;
            sched.delete();
            m_stall = 0;
            m_flush = 0;
        end else begin
            front = (sched.size() > 0) ? sched[0] : 0;
            if (front == K_DRAIN) begin
                e = 7'b0010000;
                void'(sched.pop_front());
            end else if (front == K_REDIR) begin
                e = 7'b1001010;
                void'(sched.pop_front());
            end else if (exc_req) begin
                e = {6'b001110, front == K_MD};
                sched.delete();
                for (int i = 0; i < EXC_DRAIN; i++) sched.push_back(K_DRAIN);
                sched.push_back(K_REDIR);
            end else if (front == K_MD) begin
                e = 7'b0010001;
                void'(sched.pop_front());
            end else if (md_start) begin
                e = 7'b1100000;
                for (int i = 0; i < MD_LAT; i++) sched.push_back(K_MD);
            end else if (lu_hazard || br_hazard) begin
                e = 7'b0010000;
            end else begin
                e = {3'b110, skip_flush, 3'b000};
            end
        end
        chk("pc_write",     {31'b0, pc_write},     {31'b0, e[6]});
        chk("if_id_write",  {31'b0, if_id_write},  {31'b0, e[5]});
        chk("id_ex_bubble", {31'b0, id_ex_bubble}, {31'b0, e[4]});
        chk("if_flush",     {31'b0, if_flush},     {31'b0, e[3]});
        chk("ex_flush",     {31'b0, ex_flush},     {31'b0, e[2]});
        chk("pc_sel_exc",   {31'b0, pc_sel_exc},   {31'b0, e[1]});
        chk("md_busy",      {31'b0, md_busy},      {31'b0, e[0]});
        if (rst_n && perf_ok) begin
`ifdef HAZ_PERF_EN
            chk("stall_cnt", stall_cnt, m_stall);
            chk("flush_cnt", flush_cnt, m_flush);
`else
            chk("stall_cnt", stall_cnt, 32'd0);
            chk("flush_cnt", flush_cnt, 32'd0);
`endif
        end
        if (!rst_n) begin
            perf_ok = 1'b1;
        end else begin
            if (!e[6]) m_stall++;
            if (e[3]) m_flush++;
        end
    end

    task automatic drive(input logic r, input logic lu, input logic br, input logic sk,
                         input logic md, input logic ex);
        rst_n = r; lu_hazard = lu; br_hazard = br; skip_flush = sk; md_start = md; exc_req = ex;
        #1;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input logic [6:0] exp);
        chk(name, {25'b0, pc_write, if_id_write, id_ex_bubble, if_flush, ex_flush, pc_sel_exc, md_busy},
            {25'b0, exp});
    endtask

    function automatic logic [31:0] perf_exp(input logic [31:0] v);
`ifdef HAZ_PERF_EN
        return v;
`else
        return 32'd0 & v;
`endif
    endfunction

    initial begin
        drive(1'b0, 0, 0, 0, 0, 0);
        chk_out("reset_outputs", 7'b0000000);
        next(); next(); next();
        drive(1'b1, 0, 0, 0, 0, 0); chk_out("release_idle", 7'b1100000);
        next(); drive(1'b1, 1, 0, 0, 0, 0); chk_out("lu_stall", 7'b0010000);
        next(); drive(1'b1, 0, 0, 0, 0, 0); chk_out("lu_after", 7'b1100000);
        next(); drive(1'b1, 1, 0, 1, 0, 0); chk_out("lu_skip", 7'b0010000);
        next(); drive(1'b1, 0, 0, 1, 0, 0); chk_out("skip_only", 7'b1101000);
        next(); drive(1'b1, 0, 1, 0, 0, 0); chk_out("br_stall", 7'b0010000);
        next(); drive(1'b1, 0, 0, 0, 0, 0);
        chk("perf_stall3", stall_cnt, perf_exp(32'd3));
        chk("perf_flush1", flush_cnt, perf_exp(32'd1));
        // mult/div: issue cycle idle, then MD_LAT stalled busy cycles
        next(); drive(1'b1, 0, 0, 0, 1, 0); chk_out("md_issue", 7'b1100000);
        for (int i = 0; i < MD_LAT; i++) begin
            next(); drive(1'b1, 0, 0, 0, (i == 1), 0); chk_out("md_wait", 7'b0010001);
        end
        next(); drive(1'b1, 0, 0, 0, 0, 0); chk_out("md_done", 7'b1100000);
        // exception during second MD_WAIT cycle
        next(); drive(1'b1, 0, 0, 0, 1, 0);
        next(); drive(1'b1, 0, 0, 0, 0, 0); chk_out("md_w1", 7'b0010001);
        next(); drive(1'b1, 0, 0, 0, 0, 1); chk_out("exc_accept", 7'b0011101);
        next(); drive(1'b1, 0, 0, 0, 0, 1); chk_out("drain1", 7'b0010000);
        next(); drive(1'b1, 1, 0, 0, 0, 0); chk_out("drain2", 7'b0010000);
        next(); drive(1'b1, 0, 0, 0, 0, 0); chk_out("redirect", 7'b1001010);
        next(); drive(1'b1, 0, 0, 0, 0, 0); chk_out("exc_run", 7'b1100000);
        // reset in the middle of a drain
        next(); drive(1'b1, 0, 0, 0, 0, 1);
        next(); drive(1'b1, 0, 0, 0, 0, 0); chk_out("drain_pre_rst", 7'b0010000);
        next(); drive(1'b0, 0, 0, 0, 0, 0); chk_out("rst_mid_drain", 7'b0000000);
        next(); drive(1'b0, 1, 0, 1, 1, 1); chk_out("rst_ignores_in", 7'b0000000);
        next(); drive(1'b1, 0, 0, 0, 0, 0); chk_out("rst_release", 7'b1100000);
        chk("stall_after_rst", stall_cnt, 32'd0);
        // randomised traffic, occasional short resets
        for (int n = 0; n < 4000; n++) begin
            next();
            drive(($urandom_range(199) != 0),
                  ($urandom_range(5) == 0), ($urandom_range(7) == 0), ($urandom_range(4) == 0),
                  ($urandom_range(11) == 0), ($urandom_range(19) == 0));
        end
        next(); drive(1'b1, 0, 0, 0, 0, 0);
        next(); next();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
